// File: rtl/mc_pkg.sv
// Package: mc_pkg
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction opcode / funct field constants and ALU control encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
  } state_t;

  // Opcode field, instruction bits [31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Funct field, instruction bits [5:0], R-type only.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Native ALU control encodings; the top widens/narrows to ALU_CTRL_W.
  localparam int unsigned ALU_OP_W = 3;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_alu_dec.sv
// Module: mc_alu_dec
// Combinational funct-to-ALU-control decoder for R-type instructions.
// Ports:
//   funct     in  6  instruction bits [5:0]
//   alu_op    out 3  ALU control encoding (add for unknown funct)
//   funct_bad out 1  funct is not a supported R-type operation
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                funct_bad
);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    alu_op    = ALU_ADD;
    funct_bad = 1'b0;
    unique case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Module: multicycle_ctrl
// Moore FSM controller for a multicycle MIPS-subset datapath sharing one
// instruction/data memory. Supports lw, sw, R-type, beq, addi, j.
// Optional: define MULTICYCLE_CTRL_BNE_EN to add bne (branch on ~zero);
// without it bne is an illegal opcode.
// Ports:
//   clk, reset (async, active-high)
//   opcode[5:0], funct[5:0]  instruction fields from the IR
//   zero                     ALU zero flag
//   mem_ready                memory completes the current access this cycle
//   iord, mem_write, ir_write, pc_en, pc_src[1:0], alu_src_a,
//   alu_src_b[1:0], alu_ctrl[ALU_CTRL_W-1:0], reg_dst, mem_to_reg,
//   reg_write, illegal_op    datapath control outputs
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  iord,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal_op
);

  state_t              state_q, state_d;
  logic [ALU_OP_W-1:0] alu_op, r_alu_op;
  logic                funct_bad;
  logic                bne_op;

  mc_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_op   (r_alu_op),
    .funct_bad(funct_bad)
  );

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign bne_op = (opcode == OP_BNE);
`else
  assign bne_op = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_AND;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        // The async reset already forces FETCH; the extra gating keeps the
        // IR and PC from loading while reset is still held.
        ir_write  = mem_ready & ~reset;
        pc_en     = mem_ready & ~reset;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        if (opcode == OP_LW || opcode == OP_SW) state_d = MEMADR;
        else if (opcode == OP_RTYPE)            state_d = EXEC;
        else if (opcode == OP_BEQ || bne_op)    state_d = BRANCH;
        else if (opcode == OP_ADDI)             state_d = ADDIEX;
        else if (opcode == OP_J)                state_d = JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = r_alu_op;
        illegal_op = funct_bad;
        state_d    = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = bne_op ? ~zero : zero;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench: tb_multicycle_ctrl
// Directed stimulus; each cycle's expected output vector is pushed to a
// scoreboard queue as the inputs are driven and popped when sampled.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       iord, mem_write, ir_write, pc_en, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  multicycle_ctrl #(.ALU_CTRL_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {iord, mem_write, ir_write, pc_en, pc_src, alu_src_a,
                     alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write,
                     illegal_op};

  // Expected vector, field order matching obs.
  function automatic logic [15:0] mk(input logic io, mw, irw, pce,
                                     input logic [1:0] pcs, input logic asa,
                                     input logic [1:0] asb, input logic [2:0] ac,
                                     input logic rd, m2r, rw, ill);
    return {io, mw, irw, pce, pcs, asa, asb, ac, rd, m2r, rw, ill};
  endfunction

  function automatic logic [15:0] e_fetch(input logic mr);
    return mk(0, 0, mr, mr, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_decode(input logic ill);
    return mk(0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0, ill);
  endfunction
  function automatic logic [15:0] e_memadr();
    return mk(0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_memrd();
    return mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_memwb();
    return mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1, 1, 0);
  endfunction
  function automatic logic [15:0] e_memwr();
    return mk(1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_exec(input logic [2:0] ac, input logic ill);
    return mk(0, 0, 0, 0, 2'b00, 1, 2'b00, ac, 0, 0, 0, ill);
  endfunction
  function automatic logic [15:0] e_aluwb();
    return mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0);
  endfunction
  function automatic logic [15:0] e_branch(input logic pce);
    return mk(0, 0, 0, pce, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_addiwb();
    return mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1, 0);
  endfunction
  function automatic logic [15:0] e_jump();
    return mk(0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 0);
  endfunction

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic compare();
    logic [15:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests_run++;
    assert (obs === e) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
  endtask

  task automatic expect_now(input string t, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1 compare();
  endtask

  // One clock cycle: drive, record expectation, sample mid-cycle, advance.
  task automatic cyc(input logic mr, input logic z, input string t,
                     input logic [15:0] e);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(t);
    #2 compare();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] ac_tab [6];

  initial begin
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    ac_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    reset = 1'b1;
    opcode = 6'b100011;
    funct = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Held in reset with mem_ready high: no IR/PC load.
    cyc(1, 0, "reset_hold", e_fetch(0));
    reset = 1'b0;

    // lw with memory always ready: 5 cycles.
    set_instr(6'b100011, 6'b0);
    cyc(1, 0, "lw_fetch", e_fetch(1));
    cyc(1, 0, "lw_decode", e_decode(0));
    cyc(1, 0, "lw_memadr", e_memadr());
    cyc(1, 0, "lw_memrd", e_memrd());
    cyc(1, 0, "lw_memwb", e_memwb());

    // lw with one wait state in FETCH and MEMRD.
    cyc(0, 0, "lw2_fetch_wait", e_fetch(0));
    cyc(1, 0, "lw2_fetch", e_fetch(1));
    cyc(1, 0, "lw2_decode", e_decode(0));
    cyc(1, 0, "lw2_memadr", e_memadr());
    cyc(0, 0, "lw2_memrd_wait", e_memrd());
    cyc(1, 0, "lw2_memrd", e_memrd());
    cyc(1, 0, "lw2_memwb", e_memwb());

    // sw with three wait cycles: mem_write for exactly four cycles.
    set_instr(6'b101011, 6'b0);
    cyc(1, 0, "sw_fetch", e_fetch(1));
    cyc(1, 0, "sw_decode", e_decode(0));
    cyc(1, 0, "sw_memadr", e_memadr());
    for (int i = 0; i < 3; i++) cyc(0, 0, $sformatf("sw_memwr_wait%0d", i), e_memwr());
    cyc(1, 0, "sw_memwr_done", e_memwr());

    // R-type across every funct, including an unknown one.
    for (int i = 0; i < 6; i++) begin
      set_instr(6'b000000, fn_tab[i]);
      cyc(1, 0, $sformatf("r%0d_fetch", i), e_fetch(1));
      cyc(1, 0, $sformatf("r%0d_decode", i), e_decode(0));
      cyc(1, 0, $sformatf("r%0d_exec", i), e_exec(ac_tab[i], i == 5));
      cyc(1, 0, $sformatf("r%0d_aluwb", i), e_aluwb());
    end

    // beq taken and not taken.
    set_instr(6'b000100, 6'b0);
    cyc(1, 1, "beq1_fetch", e_fetch(1));
    cyc(1, 1, "beq1_decode", e_decode(0));
    cyc(1, 1, "beq1_branch", e_branch(1));
    cyc(1, 0, "beq0_fetch", e_fetch(1));
    cyc(1, 0, "beq0_decode", e_decode(0));
    cyc(1, 0, "beq0_branch", e_branch(0));

    // addi and j.
    set_instr(6'b001000, 6'b0);
    cyc(1, 0, "addi_fetch", e_fetch(1));
    cyc(1, 0, "addi_decode", e_decode(0));
    cyc(1, 0, "addi_ex", e_memadr());
    cyc(1, 0, "addi_wb", e_addiwb());
    set_instr(6'b000010, 6'b0);
    cyc(1, 0, "j_fetch", e_fetch(1));
    cyc(1, 0, "j_decode", e_decode(0));
    cyc(1, 0, "j_jump", e_jump());

    // Illegal opcode: one-cycle pulse in DECODE, then FETCH.
    set_instr(6'b111111, 6'b0);
    cyc(1, 0, "ill_fetch", e_fetch(1));
    cyc(1, 0, "ill_decode", e_decode(1));
    cyc(0, 0, "ill_next_fetch", e_fetch(0));

    // bne depends on the build option.
    set_instr(6'b000101, 6'b0);
    cyc(1, 0, "bne_fetch", e_fetch(1));
`ifdef MULTICYCLE_CTRL_BNE_EN
    cyc(1, 0, "bne_decode", e_decode(0));
    cyc(1, 0, "bne_branch", e_branch(1));
`else
    cyc(1, 0, "bne_decode_ill", e_decode(1));
    cyc(0, 0, "bne_next_fetch", e_fetch(0));
`endif

    // Reset asserted mid-MEMWR: mem_write drops without a clock edge.
    set_instr(6'b101011, 6'b0);
    cyc(1, 0, "swr_fetch", e_fetch(1));
    cyc(1, 0, "swr_decode", e_decode(0));
    cyc(1, 0, "swr_memadr", e_memadr());
    mem_ready = 1'b0;
    expect_now("swr_memwr", e_memwr());
    reset = 1'b1;
    expect_now("swr_async_reset", e_fetch(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1, 0, "swr_after_fetch", e_fetch(1));
    cyc(1, 0, "swr_after_decode", e_decode(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, SHALL set the alu_ctrl width.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 opcode  input  6  SHALL carry instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  SHALL carry instruction bits [5:0].
REQ-006 zero  input  1  SHALL carry the ALU zero flag.
REQ-007 mem_ready  input  1  SHALL indicate that the shared instruction/data memory completes the current access this cycle.
REQ-008 Outputs SHALL be: iord 1, mem_write 1, ir_write 1, pc_en 1, pc_src 2, alu_src_a 1, alu_src_b 2, alu_ctrl ALU_CTRL_W, reg_dst 1, mem_to_reg 1, reg_write 1, illegal_op 1.

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-010 FETCH SHALL drive iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add(010), pc_src=00; ir_write and pc_en SHALL be 1 only in a cycle where mem_ready=1; FETCH SHALL be held until mem_ready=1, then go to DECODE.
REQ-011 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_ctrl=add, and go by opcode: lw(100011)/sw(101011)->MEMADR, R-type(000000)->EXEC, beq(000100)->BRANCH, addi(001000)->ADDIEX, j(000010)->JUMP.
REQ-012 Any other opcode in DECODE SHALL pulse illegal_op=1 for that cycle and return to FETCH with no write enable asserted.
REQ-013 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=add; next MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD SHALL drive iord=1 and wait until mem_ready=1, then go to MEMWB.
REQ-015 MEMWB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-016 MEMWR SHALL drive iord=1, mem_write=1 continuously until the cycle mem_ready=1, then go to FETCH.
REQ-017 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct: add 100000->010, sub 100010->110, and 100100->000, or 100101->001, slt 101010->111; unknown funct SHALL decode to 010 and pulse illegal_op; next ALUWB.
REQ-018 ALUWB SHALL drive reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl=sub, pc_src=01, pc_en=zero; next FETCH.
REQ-020 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_ctrl=add; ADDIWB SHALL drive reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH.
REQ-021 JUMP SHALL drive pc_src=10, pc_en=1; next FETCH.
REQ-022 Any output not listed for a state SHALL be 0.
REQ-023 Cycle counts with mem_ready tied 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-024 Reset assertion SHALL force state FETCH immediately, including mid-instruction.
REQ-025 While reset=1, ir_write, pc_en, mem_write, reg_write and illegal_op SHALL be 0; other outputs SHALL equal FETCH values.
REQ-026 First FETCH access SHALL begin in the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MULTICYCLE_CTRL_BNE_EN defined: opcode bne(000101) SHALL enter BRANCH with pc_en=~zero.
REQ-028 Macro undefined: bne SHALL be treated as illegal per REQ-012.

Structure
REQ-029 Package mc_pkg SHALL hold the state enum, opcode and funct constants, and alu_ctrl encodings.
REQ-030 The funct-to-alu_ctrl decode SHALL be a combinational sub-module mc_alu_dec.

Verification
REQ-031 lw (opcode 100011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-032 sw with mem_ready low 3 cycles in MEMWR -> mem_write=1 for exactly 4 cycles, then FETCH.
REQ-033 beq with zero=1 -> pc_en=1, pc_src=01 in cycle 3; with zero=0 -> pc_en=0.
REQ-034 R-type funct 101010 -> alu_ctrl=111 in EXEC, reg_dst=1 in ALUWB.
REQ-035 opcode 111111 -> illegal_op one-cycle pulse in DECODE, no writes, next FETCH.
REQ-036 reset asserted during MEMWR -> mem_write drops asynchronously; state FETCH after release.
